// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port I2C responder: accepts 3-byte register writes addressed to
// DEVICE_ADDR, ACKs them on an oversampled bus and mirrors the codec's 9-bit registers.
module wm8731_i2c_responder #(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [3:0] reg_rd_addr,
    output logic [8:0] reg_rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, IGNORE
    } state_t;

    function automatic logic [8:0] default_value(input logic [3:0] idx);
        logic [8:0] val;
        case (idx)
            4'd0:    val = 9'h097;
            4'd1:    val = 9'h097;
            4'd2:    val = 9'h079;
            4'd3:    val = 9'h079;
            4'd4:    val = 9'h00A;
            4'd5:    val = 9'h008;
            4'd6:    val = 9'h09F;
            4'd7:    val = 9'h00A;
            default: val = 9'h000;
        endcase
        return val;
    endfunction

    state_t     state_r;
    logic       scl_s1_r, scl_s2_r, scl_h_r;
    logic       sda_s1_r, sda_s2_r, sda_h_r;
    logic [3:0] cnt_r;
    logic [7:0] shreg_r;
    logic [7:0] byte1_r;
    logic [8:0] shadow_r [0:9];
    logic       scl_rise_s, scl_fall_s, start_s, stop_s;

    // Pin synchronizers plus one history stage; idle bus is high on both lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {scl_s1_r, scl_s2_r, scl_h_r} <= 3'b111;
            {sda_s1_r, sda_s2_r, sda_h_r} <= 3'b111;
        end else begin
            {scl_s1_r, scl_s2_r, scl_h_r} <= {scl_in, scl_s1_r, scl_s2_r};
            {sda_s1_r, sda_s2_r, sda_h_r} <= {sda_in, sda_s1_r, sda_s2_r};
        end
    end

    // START/STOP require SCL stable high across the SDA edge, so a coincident edge is data.
    assign scl_rise_s = scl_s2_r & ~scl_h_r;
    assign scl_fall_s = ~scl_s2_r & scl_h_r;
    assign start_s    = scl_s2_r & scl_h_r & sda_h_r & ~sda_s2_r;
    assign stop_s     = scl_s2_r & scl_h_r & ~sda_h_r & sda_s2_r;

    // Protocol FSM: bits shift on SCL rise, ACK drive/release and commit happen on SCL fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            shreg_r   <= 8'h00;
            byte1_r   <= 8'h00;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'h00;
            wr_data   <= 9'h000;
            busy      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_s) begin
                state_r <= ADDR;
                cnt_r   <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_s) begin
                state_r <= IDLE;
                cnt_r   <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ADDR, BYTE1, BYTE2: begin
                        if (cnt_r < 4'd8) begin
                            shreg_r <= {shreg_r[6:0], sda_s2_r};
                            cnt_r   <= cnt_r + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ADDR: begin
                        if (cnt_r == 4'd8) begin
                            if (shreg_r == {DEVICE_ADDR, 1'b0}) begin
                                state_r <= ACK_A;
                                sda_oe  <= 1'b1;
                            end else begin
                                state_r <= IGNORE;
                            end
                        end
                    end
                    BYTE1: begin
                        if (cnt_r == 4'd8) begin
                            byte1_r <= shreg_r;
                            state_r <= ACK1;
                            sda_oe  <= 1'b1;
                        end
                    end
                    BYTE2: begin
                        if (cnt_r == 4'd8) begin
                            state_r <= ACK2;
                            sda_oe  <= 1'b1;
                        end
                    end
                    ACK_A: begin
                        state_r <= BYTE1;
                        sda_oe  <= 1'b0;
                        cnt_r   <= 4'd0;
                    end
                    ACK1: begin
                        state_r <= BYTE2;
                        sda_oe  <= 1'b0;
                        cnt_r   <= 4'd0;
                    end
                    ACK2: begin
                        // shreg_r still holds byte 2: ACK clocks never shift.
                        state_r   <= IGNORE;
                        sda_oe    <= 1'b0;
                        wr_strobe <= 1'b1;
                        wr_addr   <= byte1_r[7:1];
                        wr_data   <= {byte1_r[0], shreg_r};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shadow registers take the committed write one cycle after the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 10; i++) shadow_r[i] <= default_value(4'(i));
        end else if (wr_strobe) begin
            if (wr_addr == 7'h0F) begin
                for (int i = 0; i < 10; i++) shadow_r[i] <= default_value(4'(i));
            end else if (wr_addr <= 7'd9) begin
                shadow_r[wr_addr[3:0]] <= wr_data;
            end
        end
    end

    // Combinational read port; unimplemented addresses read zero.
    always_comb begin
        reg_rd_data = 9'h000;
        if (reg_rd_addr <= 4'd9) begin
            reg_rd_data = shadow_r[reg_rd_addr];
        end else begin
            reg_rd_data = 9'h000;
        end
    end

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder: bit-banged I2C master, vector table plus
// hand sequences for abort and asynchronous reset.
module tb_wm8731_i2c_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] reg_rd_addr = 4'd0;
    logic [8:0] reg_rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;

    int pass_cnt = 0;
    int total = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [3:0]  ack;
        int          strobes;
        logic [6:0]  wa;
        logic [8:0]  wd;
        logic [3:0]  rd;
        logic [8:0]  rdexp;
    } vec_t;

    vec_t vecs [9];

    assign sda_line = sda_m & ~sda_oe;

    wm8731_i2c_responder dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt++;
        if (sda_oe) oe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b0; wait_clk(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(5);
        scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b1; wait_clk(10);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_clk(5);
            scl_m = 1'b1; wait_clk(10);
            scl_m = 1'b0; wait_clk(5);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        sda_m = 1'b1; wait_clk(5);
        scl_m = 1'b1; wait_clk(5);
        ack = sda_oe;
        wait_clk(5);
        scl_m = 1'b0; wait_clk(5);
    endtask

    task automatic read_reg(input logic [3:0] a, input logic [8:0] exp, input string name);
        reg_rd_addr = a;
        #1;
        check(name, 32'(reg_rd_data), 32'(exp));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] acks;
        logic       a;
        int         s0, oe0;
        acks = 4'b0000;
        s0 = strobe_cnt;
        oe0 = oe_cnt;
        i2c_start();
        check($sformatf("busy_hi[%0d]", idx), 32'(busy), 32'd1);
        for (int k = 0; k < v.n; k++) begin
            send_byte(v.bytes[31-8*k -: 8], a);
            acks[k] = a;
        end
        i2c_stop();
        check($sformatf("acks[%0d]", idx), 32'(acks), 32'(v.ack));
        check($sformatf("strobes[%0d]", idx), 32'(strobe_cnt - s0), 32'(v.strobes));
        if (v.ack == 4'b0000) check($sformatf("oe_quiet[%0d]", idx), 32'(oe_cnt - oe0), 32'd0);
        if (v.strobes != 0) begin
            check($sformatf("wr_addr[%0d]", idx), 32'(wr_addr), 32'(v.wa));
            check($sformatf("wr_data[%0d]", idx), 32'(wr_data), 32'(v.wd));
        end
        read_reg(v.rd, v.rdexp, $sformatf("rd[%0d]", idx));
        check($sformatf("busy_lo[%0d]", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        logic a0, a1;
        int   s0;

        vecs[0] = '{3, 32'h36081200, 4'b0000, 0, 7'h00, 9'h000, 4'd4, 9'h00A};
        vecs[1] = '{3, 32'h34081200, 4'b0111, 1, 7'h04, 9'h012, 4'd4, 9'h012};
        vecs[2] = '{1, 32'h35000000, 4'b0000, 0, 7'h00, 9'h000, 4'd4, 9'h012};
        vecs[3] = '{3, 32'h340DFF00, 4'b0111, 1, 7'h06, 9'h1FF, 4'd6, 9'h1FF};
        vecs[4] = '{3, 32'h34010000, 4'b0111, 1, 7'h00, 9'h100, 4'd0, 9'h100};
        vecs[5] = '{4, 32'h341E0055, 4'b0111, 1, 7'h0F, 9'h000, 4'd0, 9'h097};
        vecs[6] = '{3, 32'h3414AB00, 4'b0111, 1, 7'h0A, 9'h0AB, 4'd10, 9'h000};
        vecs[7] = '{3, 32'h34035500, 4'b0111, 1, 7'h01, 9'h155, 4'd1, 9'h155};
        vecs[8] = '{3, 32'h34133C00, 4'b0111, 1, 7'h09, 9'h13C, 4'd9, 9'h13C};

        // Reset state
        wait_clk(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        read_reg(4'd0, 9'h097, "rst_r0");
        read_reg(4'd5, 9'h008, "rst_r5");
        read_reg(4'd12, 9'h000, "rst_r12");
        reset_n = 1'b1;
        wait_clk(10);

        // Abort after byte 1: acks given, nothing committed
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0C, a1);
        i2c_stop();
        check("abort_ack0", 32'(a0), 32'd1);
        check("abort_ack1", 32'(a1), 32'd1);
        check("abort_strobes", 32'(strobe_cnt - s0), 32'd0);
        read_reg(4'd6, 9'h09F, "abort_r6");
        check("abort_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Register-reset command earlier restored these; nothing rewrote them after.
        read_reg(4'd6, 9'h09F, "post_r6");
        read_reg(4'd4, 9'h00A, "post_r4");

        // Async reset while the byte-2 ACK is being driven
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h09, a1);
        send_bits(8'h77);
        wait_clk(5);
        check("ack2_driven", 32'(sda_oe), 32'd1);
        #5 reset_n = 1'b0;
        #1;
        check("async_sda_oe", 32'(sda_oe), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        read_reg(4'd1, 9'h097, "async_r1");
        read_reg(4'd9, 9'h000, "async_r9");
        read_reg(4'd4, 9'h00A, "async_r4");
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(5);
        check("async_strobes", 32'(strobe_cnt - s0), 32'd0);
        reset_n = 1'b1;
        wait_clk(10);
        run_vec(vecs[1], 9);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
